// File: rtl/dual_port_ram_if.sv
// Request/response bundle for dual_port_ram: one write port, one read port,
// read-data return and clear status.
interface dual_port_ram_if #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [NB-1:0]    wr_be;
  logic [WIDTH-1:0] wr_data;
  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             init_busy;

  modport master (
    output wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, init_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_be, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, init_busy
  );
endinterface

// File: rtl/dual_port_ram.sv
// Simple dual-port RAM with byte-enabled writes, 1- or 2-cycle registered reads,
// selectable same-address collision behaviour and a self-clearing init sequence.
module dual_port_ram #(
  parameter int DEPTH    = 16,
  parameter int WIDTH    = 32,
  parameter int RD_LAT   = 1,
  parameter int WR_FIRST = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  dual_port_ram_if.slave io_bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;

  localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
    $error("dual_port_ram: RD_LAT must be 1 or 2");
  end
  if (WIDTH % 8 != 0 || WIDTH < 8) begin : g_bad_width
    $error("dual_port_ram: WIDTH must be a non-zero multiple of 8");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("dual_port_ram: DEPTH must be at least 2");
  end

  logic [0:0]       r_state;
  logic [AW-1:0]    r_clr_cnt;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;

  logic             w_ready;
  logic             w_wr_ok;
  logic             w_rd_fire;
  logic             w_rd_in_range;
  logic             w_collide;
  logic [WIDTH-1:0] w_merged;
  logic [WIDTH-1:0] w_rd_word;
  logic             w_out_valid;
  logic [WIDTH-1:0] w_out_data;

  // Clear sequencer: walks every address once after reset, then parks in READY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= '0;
    end else if (r_state == S_CLEAR) begin
      if (r_clr_cnt == LAST_ADDR) begin
        r_state <= S_READY;
      end else begin
        r_clr_cnt <= r_clr_cnt + AW'(1);
      end
    end
  end

  assign w_ready       = (r_state == S_READY);
  assign w_wr_ok       = w_ready && io_bus.wr_en && ({1'b0, io_bus.wr_addr} < DEPTH_W);
  assign w_rd_fire     = w_ready && io_bus.rd_en;
  assign w_rd_in_range = ({1'b0, io_bus.rd_addr} < DEPTH_W);
  assign w_collide     = w_wr_ok && w_rd_fire && w_rd_in_range &&
                         (io_bus.wr_addr == io_bus.rd_addr);

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_merged = r_mem[io_bus.wr_addr];
    for (int b = 0; b < NB; b++) begin
      if (io_bus.wr_be[b]) begin
        w_merged[8*b +: 8] = io_bus.wr_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    w_rd_word = '0;
    if (w_rd_in_range) begin
      w_rd_word = (WR_FIRST != 0 && w_collide) ? w_merged : r_mem[io_bus.rd_addr];
    end
  end

  // NOTE: the array has no reset branch; a reset would turn it into flops, so zeroing is done by the clear sequencer instead.
  always_ff @(posedge clk) begin
    if (!w_ready) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_wr_ok) begin
      r_mem[io_bus.wr_addr] <= w_merged;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic             r_p1_valid;
    logic [WIDTH-1:0] r_p1_data;

    // The word is captured when the read is sampled, so later writes cannot disturb it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_p1_valid <= 1'b0;
        r_p1_data  <= '0;
      end else begin
        r_p1_valid <= w_rd_fire;
        if (w_rd_fire) begin
          r_p1_data <= w_rd_word;
        end
      end
    end

    assign w_out_valid = r_p1_valid;
    assign w_out_data  = r_p1_data;
  end else begin : g_lat1
    assign w_out_valid = w_rd_fire;
    assign w_out_data  = w_rd_word;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_out_valid;
      if (w_out_valid) begin
        r_rd_data <= w_out_data;
      end
    end
  end

  assign io_bus.rd_data   = r_rd_data;
  assign io_bus.rd_valid  = r_rd_valid;
  assign io_bus.init_busy = (r_state == S_CLEAR);

endmodule

// File: tb/tb_dual_port_ram.sv
// Scoreboard bench: two RAM instances (16 words/RD_LAT 1/read-old and
// 10 words/RD_LAT 2/write-first) share one randomized stimulus stream.
module tb_dual_port_ram;

  localparam int WIDTH = 32;
  localparam int DEP_A = 16;
  localparam int DEP_B = 10;
  localparam int LAT_A = 1;
  localparam int LAT_B = 2;
  localparam int WF_A  = 0;
  localparam int WF_B  = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        s_wr_en;
  logic [3:0]  s_wr_addr;
  logic [3:0]  s_wr_be;
  logic [31:0] s_wr_data;
  logic        s_rd_en;
  logic [3:0]  s_rd_addr;

  dual_port_ram_if #(.DEPTH(DEP_A), .WIDTH(WIDTH)) ifa ();
  dual_port_ram_if #(.DEPTH(DEP_B), .WIDTH(WIDTH)) ifb ();

  assign ifa.wr_en = s_wr_en;  assign ifb.wr_en = s_wr_en;
  assign ifa.wr_addr = s_wr_addr;  assign ifb.wr_addr = s_wr_addr;
  assign ifa.wr_be = s_wr_be;  assign ifb.wr_be = s_wr_be;
  assign ifa.wr_data = s_wr_data;  assign ifb.wr_data = s_wr_data;
  assign ifa.rd_en = s_rd_en;  assign ifb.rd_en = s_rd_en;
  assign ifa.rd_addr = s_rd_addr;  assign ifb.rd_addr = s_rd_addr;

  dual_port_ram #(.DEPTH(DEP_A), .WIDTH(WIDTH), .RD_LAT(LAT_A), .WR_FIRST(WF_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .io_bus(ifa)
  );
  dual_port_ram #(.DEPTH(DEP_B), .WIDTH(WIDTH), .RD_LAT(LAT_B), .WR_FIRST(WF_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .io_bus(ifb)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic [31:0] mem_m [2][16];
  int          busy_left [2];
  logic [31:0] last_d [2];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  function automatic int dep_of(input int k);
    return (k == 0) ? DEP_A : DEP_B;
  endfunction
  function automatic int lat_of(input int k);
    return (k == 0) ? LAT_A : LAT_B;
  endfunction
  function automatic int wf_of(input int k);
    return (k == 0) ? WF_A : WF_B;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    return res;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: the memory is a plain array, the clear is just a count of
  // DEPTH swallowed edges, and each accepted read is queued with its due edge.
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) mem_m[k][i] = '0;
      busy_left[k] = dep_of(k);
    end
    q_a.delete();
    q_b.delete();
  endtask

  task automatic model_step(input int k);
    exp_t        e;
    logic [31:0] rdw;
    logic        wr_ok;
    if (busy_left[k] > 0) begin
      busy_left[k]--;
      return;
    end
    wr_ok = s_wr_en && (int'(s_wr_addr) < dep_of(k));
    if (s_rd_en) begin
      if (int'(s_rd_addr) >= dep_of(k)) begin
        rdw = '0;
      end else begin
        rdw = mem_m[k][s_rd_addr];
        if (wf_of(k) != 0 && wr_ok && s_wr_addr == s_rd_addr) rdw = merge(rdw, s_wr_data, s_wr_be);
      end
      e.due  = cyc + lat_of(k) - 1;
      e.data = rdw;
      if (k == 0) q_a.push_back(e);
      else        q_b.push_back(e);
    end
    if (wr_ok) mem_m[k][s_wr_addr] = merge(mem_m[k][s_wr_addr], s_wr_data, s_wr_be);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
  end

  always @(negedge rst_n) begin
    q_a.delete();
    q_b.delete();
  end

  task automatic mon(input int k, input logic valid, input logic [31:0] data, input logic busy);
    exp_t e;
    bit   have;
    have = 1'b0;
    check($sformatf("init_busy_%0d", k), {31'd0, busy}, {31'd0, busy_left[k] > 0});
    if (k == 0) begin
      have = (q_a.size() > 0);
      if (have) e = q_a[0];
    end else begin
      have = (q_b.size() > 0);
      if (have) e = q_b[0];
    end
    if (valid) begin
      if (!have) begin
        check($sformatf("rd_valid_spurious_%0d", k), {31'd0, valid}, 32'd0);
      end else begin
        if (k == 0) void'(q_a.pop_front());
        else        void'(q_b.pop_front());
        check($sformatf("rd_latency_%0d", k), cyc, e.due);
        check($sformatf("rd_data_%0d", k), data, e.data);
        last_d[k] = e.data;
      end
    end else begin
      check($sformatf("rd_hold_%0d", k), data, last_d[k]);
      if (have && e.due <= cyc) begin
        check($sformatf("rd_valid_missing_%0d", k), {31'd0, valid}, 32'd1);
        if (k == 0) void'(q_a.pop_front());
        else        void'(q_b.pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0, ifa.rd_valid, ifa.rd_data, ifa.init_busy);
      mon(1, ifb.rd_valid, ifb.rd_data, ifb.init_busy);
    end else begin
      check("rst_busy_a", {31'd0, ifa.init_busy}, 32'd1);
      check("rst_busy_b", {31'd0, ifb.init_busy}, 32'd1);
      check("rst_valid_a", {31'd0, ifa.rd_valid}, 32'd0);
      check("rst_valid_b", {31'd0, ifb.rd_valid}, 32'd0);
      check("rst_data_a", ifa.rd_data, 32'd0);
      check("rst_data_b", ifb.rd_data, 32'd0);
      last_d[0] = '0;
      last_d[1] = '0;
    end
  end

  task automatic drive(input logic we, input logic [3:0] wa, input logic [3:0] be,
                       input logic [31:0] wd, input logic re, input logic [3:0] ra);
    s_wr_en = we; s_wr_addr = wa; s_wr_be = be; s_wr_data = wd;
    s_rd_en = re; s_rd_addr = ra;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b0, 4'd0);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++)
      drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom), $urandom,
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
  endtask

  task automatic read_all();
    for (int a = 0; a < 16; a++) drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'(a));
  endtask

  initial begin
    rst_n = 1'b1;
    s_wr_en = 1'b0; s_wr_addr = '0; s_wr_be = '0; s_wr_data = '0;
    s_rd_en = 1'b0; s_rd_addr = '0;
    last_d[0] = '0;
    last_d[1] = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Power-up clear, then every word reads zero.
    idle(17);
    read_all();
    idle(3);

    // Byte-enable merge on address 3.
    drive(1'b1, 4'd3, 4'b1111, 32'hAABBCCDD, 1'b0, 4'd0);
    drive(1'b1, 4'd3, 4'b0101, 32'h11223344, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd3);
    idle(3);
    check("be_merge_a", ifa.rd_data, 32'hAA22CC44);
    check("be_merge_b", ifb.rd_data, 32'hAA22CC44);

    // Same-edge collision on address 5.
    drive(1'b1, 4'd5, 4'b1111, 32'h0, 1'b0, 4'd0);
    drive(1'b1, 4'd5, 4'b0011, 32'hFFFFFFFF, 1'b1, 4'd5);
    idle(3);
    check("collide_read_old_a", ifa.rd_data, 32'h00000000);
    check("collide_write_first_b", ifb.rd_data, 32'h0000FFFF);

    // Back-to-back reads, then a write with all byte enables off.
    drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd1);
    drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd2);
    drive(1'b1, 4'd3, 4'b0000, 32'h12345678, 1'b1, 4'd3);
    drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd3);
    idle(3);

    // Address 12 is beyond the 10-word instance.
    drive(1'b1, 4'd12, 4'b1111, 32'hCAFEF00D, 1'b0, 4'd0);
    drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd12);
    idle(3);
    check("oob_read_b", ifb.rd_data, 32'd0);
    read_all();
    idle(3);

    rand_cycles(400);

    // Reset at clr_cnt == 7, with requests offered throughout the clear.
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    rand_cycles(7);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    rand_cycles(22);
    rand_cycles(100);

    // Reset while a read is in flight.
    drive(1'b0, 4'd0, 4'd0, 32'd0, 1'b1, 4'd2);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(17);
    read_all();
    rand_cycles(200);
    idle(4);
    check("scoreboard_drained", q_a.size() + q_b.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dual_port_ram.md
DUAL_PORT_RAM -- requirements
Module: dual_port_ram

Interface
REQ-001 Parameter DEPTH, default 16, number of words; SHALL be >= 2 and need not be a power of two.
REQ-002 Parameter WIDTH, default 32, word width in bits; SHALL be an integer multiple of 8.
REQ-003 Parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2; any other value SHALL fail elaboration.
REQ-004 Parameter WR_FIRST, default 0, same-address collision mode (0 = read-old, 1 = write-first).
REQ-005 Localparams: AW = $clog2(DEPTH); NB = WIDTH/8.
REQ-006 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 wr_en  input  1  write request, sampled at the rising edge of clk.
REQ-010 wr_addr  input  AW  write word address.
REQ-011 wr_be  input  NB  byte enables; bit i enables wr_data[8i+7:8i].
REQ-012 wr_data  input  WIDTH  write data.
REQ-013 rd_en  input  1  read request, sampled at the rising edge of clk.
REQ-014 rd_addr  input  AW  read word address.
REQ-015 rd_data  output  WIDTH  read data, registered.
REQ-016 rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-017 init_busy  output  1  high while the memory-clear sequence runs; requests are ignored while it is high.

Function
REQ-018 Two-state FSM:
- CLEAR: each edge writes 0 to mem[clr_cnt].
- If clr_cnt == DEPTH-1, the FSM moves to READY; otherwise clr_cnt increments.
REQ-019 init_busy SHALL equal (state == CLEAR); it therefore falls on the DEPTH-th rising edge after rst_n deasserts.
REQ-020 In READY, a write with wr_en=1 and wr_addr < DEPTH SHALL update only the bytes whose wr_be bit is set.
REQ-021 A write with wr_be = 0 SHALL leave the addressed word unchanged.
REQ-022 A write with wr_addr >= DEPTH SHALL be ignored.
REQ-023 In READY, read latency:
- rd_en=1 sampled at edge N SHALL produce rd_valid=1 and rd_data=mem[rd_addr] after edge N+RD_LAT-1.
- rd_valid SHALL be high for exactly one cycle per accepted read.
REQ-024 Back-to-back reads on consecutive edges SHALL each produce one rd_valid pulse, with full throughput at either RD_LAT.
REQ-025 A read with rd_addr >= DEPTH SHALL return rd_data = 0 with rd_valid = 1.
REQ-026 When no read completes, rd_data SHALL hold its last value and rd_valid SHALL be 0.
REQ-027 Same-edge read and write to the same in-range address:
- WR_FIRST=0: rd_data SHALL be the pre-write word.
- WR_FIRST=1: rd_data SHALL be the merged word (enabled bytes new, other bytes old).
REQ-028 Requests sampled while init_busy=1 SHALL be dropped: no memory change and no rd_valid.
REQ-029 Reads in the RD_LAT=2 pipeline SHALL complete normally regardless of later inputs.

Reset
REQ-030 While rst_n=0:
- state=CLEAR, clr_cnt=0, init_busy=1.
- rd_data=0, rd_valid=0, and the RD_LAT=2 pipeline stage is cleared.
REQ-031 Asserting rst_n mid-CLEAR SHALL restart the clear from address 0.
REQ-032 Asserting rst_n in READY SHALL discard in-flight reads and re-run the full clear sequence after release.
REQ-033 After the clear completes, every word SHALL read 0.

Verification
REQ-034 Power-up clear: release rst_n with DEPTH=16 -> init_busy high for exactly 16 edges; reads of addresses 0..15 then return 0 with one rd_valid each.
REQ-035 Byte enables: write 0xAABBCCDD to addr 3 with be=1111, then 0x11223344 with be=0101, then read addr 3 -> 0xAA22CC44.
REQ-036 Collision: mem[5]=0x0, same-edge write 0xFFFFFFFF be=0011 and read of addr 5 -> WR_FIRST=0 returns 0x00000000; WR_FIRST=1 returns 0x0000FFFF.
REQ-037 Latency and throughput: RD_LAT=2, reads of addrs 1,2,3 on consecutive edges -> three consecutive rd_valid pulses, the first two edges after the first request, data in order.
REQ-038 Reset mid-operation: pulse rst_n low at clr_cnt=7, and again with a RD_LAT=2 read in flight -> no rd_valid; init_busy high for the full 16 edges after each release; memory all zero.
REQ-039 Boundary: DEPTH=10, write to addr 12, then read addr 12 -> memory unchanged; rd_data=0, rd_valid=1.
